// File: rtl/vpu_issue_responder_pkg.sv
// Shared OVI bus definitions, widths and the execute-length helper for the VPU issue responder.
// Related optional feature macro: OVI_RESP_ILLEGAL_CHECK_EN (consumed by vpu_issue_responder).
`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 16
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif

package vpu_issue_responder_pkg;

    localparam int INSTR_W = `OVI_INSTR_WIDTH;
    localparam int VL_W    = `OVI_VL_WIDTH;
    localparam int SEW_W   = `OVI_SEW_WIDTH;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [VL_W-1:0]    vl;
        logic [SEW_W-1:0]   sew;
        logic               valid;
    } core_issue_bus;

    typedef struct packed {
        logic               valid;
        logic               illegal;
        logic [INSTR_W-1:0] instr;
    } core_completed_bus;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [VL_W-1:0]    vl;
        logic [SEW_W-1:0]   sew;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

    // Number of execute cycles for an op: ceil(vl / 2**lanes_log2), never below one.
    function automatic logic [VL_W-1:0] exec_len(input logic [VL_W-1:0] vl,
                                                 input int unsigned lanes_log2);
        logic [VL_W:0] round_up;
        logic [VL_W:0] len;
        round_up = {1'b0, vl} + ((VL_W+1)'(1) << lanes_log2) - (VL_W+1)'(1);
        len      = round_up >> lanes_log2;
        if (len == '0) begin
            len = (VL_W+1)'(1);
        end
        return VL_W'(len);
    endfunction

endpackage

// File: rtl/vpu_issue_responder_if.sv
// Issue / completion bus bundle between the core (master) and the VPU issue responder (slave).
interface vpu_issue_responder_if;
    import vpu_issue_responder_pkg::*;

    core_issue_bus     CORE_ISSUE;
    logic              ISSUE_READY;
    core_completed_bus CORE_COMPLETED;
    logic              BUSY;

    modport master (
        output CORE_ISSUE,
        input  ISSUE_READY,
        input  CORE_COMPLETED,
        input  BUSY
    );

    modport slave (
        input  CORE_ISSUE,
        output ISSUE_READY,
        output CORE_COMPLETED,
        output BUSY
    );
endinterface

// File: rtl/ovi_issue_fifo.sv
// Power-of-two issue FIFO with wrapping pointers, occupancy count and first-word-fall-through head.
module ovi_issue_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so natural overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vpu_issue_responder.sv
// VPU issue responder: queues core issues, models execute time per op, reports in-order completions.
// Optional feature macro: OVI_RESP_ILLEGAL_CHECK_EN (ops with sew=3 are retired as illegal).
module vpu_issue_responder
    import vpu_issue_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 4
) (
    input logic                  CLK,
    input logic                  RSTN,
    vpu_issue_responder_if.slave ovi
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam int unsigned LANES_LOG2 = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        COMPLETE
    } state_t;

    issue_entry_t      wr_entry;
    issue_entry_t      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_count;
    logic              head_illegal;

    state_t            state_reg;
    logic [VL_W-1:0]   cnt_reg;
    logic [INSTR_W-1:0] op_instr_reg;
    logic              op_illegal_reg;
    core_completed_bus completed_reg;

    assign wr_entry = '{instr: ovi.CORE_ISSUE.instr,
                        vl:    ovi.CORE_ISSUE.vl,
                        sew:   ovi.CORE_ISSUE.sew};

    assign fifo_pop = (state_reg != EXEC) && !fifo_empty;

    ovi_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (ovi.CORE_ISSUE.valid),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef OVI_RESP_ILLEGAL_CHECK_EN
    assign head_illegal = (head.sew == SEW_W'(3));
`else
    logic sew_unused;
    assign head_illegal = 1'b0;
    assign sew_unused   = ^head.sew;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            op_instr_reg   <= '0;
            op_illegal_reg <= 1'b0;
            completed_reg  <= '0;
        end else begin
            completed_reg <= '0;
            case (state_reg)
                // COMPLETE also picks up the next op, so back-to-back ops retire every L+1 cycles.
                IDLE, COMPLETE: begin
                    if (!fifo_empty) begin
                        op_instr_reg   <= head.instr;
                        op_illegal_reg <= head_illegal;
                        // An illegal op is not executed; it only occupies the minimum one-cycle slot.
                        cnt_reg        <= head_illegal ? VL_W'(1) : exec_len(head.vl, LANES_LOG2);
                        state_reg      <= EXEC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_reg == VL_W'(1)) begin
                        state_reg     <= COMPLETE;
                        completed_reg <= '{valid:   1'b1,
                                           illegal: op_illegal_reg,
                                           instr:   op_instr_reg};
                    end else begin
                        cnt_reg <= cnt_reg - VL_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ovi.ISSUE_READY    = !fifo_full;
    assign ovi.CORE_COMPLETED = completed_reg;
    assign ovi.BUSY           = (fifo_count != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_vpu_issue_responder.sv
// Directed self-checking bench for vpu_issue_responder (DEPTH=4, LANES=4).
module tb_vpu_issue_responder;
    import vpu_issue_responder_pkg::*;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;

    vpu_issue_responder_if ovi ();

    vpu_issue_responder #(
        .DEPTH (4),
        .LANES (4)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .ovi  (ovi.slave)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [INSTR_W-1:0] done_instr[$];
    int                 done_cyc[$];
    logic               done_ill[$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (ovi.CORE_COMPLETED.valid === 1'b1) begin
            done_instr.push_back(ovi.CORE_COMPLETED.instr);
            done_cyc.push_back(cyc);
            done_ill.push_back(ovi.CORE_COMPLETED.illegal);
            $display("[TB] cycle %0d completion instr=%0h illegal=%0b", cyc,
                     ovi.CORE_COMPLETED.instr, ovi.CORE_COMPLETED.illegal);
        end else begin
            check("idle_zero", {ovi.CORE_COMPLETED.illegal, ovi.CORE_COMPLETED.instr}, 64'd0);
        end
    endtask

    task automatic issue(input logic [INSTR_W-1:0] instr, input logic [VL_W-1:0] vl,
                         input logic [SEW_W-1:0] sew, output int acc_cyc);
        check("ready_before_issue", ovi.ISSUE_READY, 64'd1);
        ovi.CORE_ISSUE = '{instr: instr, vl: vl, sew: sew, valid: 1'b1};
        tick();
        acc_cyc = cyc;
        ovi.CORE_ISSUE = '0;
        $display("[TB] cycle %0d issue instr=%0h vl=%0d sew=%0d", cyc, instr, vl, sew);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((ovi.BUSY === 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        check("drain_in_budget", ovi.BUSY, 64'd0);
    endtask

    task automatic clear_done();
        done_instr.delete();
        done_cyc.delete();
        done_ill.delete();
    endtask

    task automatic expect_done(input string tag, input int idx, input logic [INSTR_W-1:0] instr,
                               input int acc, input int lat, input logic ill);
        if (idx < done_instr.size()) begin
            check({tag, "_instr"}, done_instr[idx], 64'(instr));
            check({tag, "_latency"}, 64'(done_cyc[idx] - acc), 64'(lat));
            check({tag, "_illegal"}, done_ill[idx], 64'(ill));
        end
    endtask

    initial begin
        int a;
        int a0;
        int vl_tab[5];
        int lat_tab[5];

        ovi.CORE_ISSUE = '0;
        tick();
        tick();
        check("rst_ready", ovi.ISSUE_READY, 64'd1);
        check("rst_busy", ovi.BUSY, 64'd0);
        check("rst_completed", ovi.CORE_COMPLETED, 64'd0);

        // Single op straight out of reset: vl=8 -> L=2, completion 3 cycles after accept.
        RSTN = 1'b1;
        clear_done();
        issue(32'hDEADCAFE, 8, 2, a);
        check("t1_busy", ovi.BUSY, 64'd1);
        drain(20);
        check("t1_count", done_instr.size(), 64'd1);
        expect_done("t1", 0, 32'hDEADCAFE, a, 3, 1'b0);

        // Length table: latency = max(1, ceil(vl/4)) + 1.
        vl_tab  = '{0, 1, 4, 5, 16};
        lat_tab = '{2, 2, 2, 3, 5};
        for (int i = 0; i < 5; i++) begin
            clear_done();
            issue(32'h1100_0000 + 32'(i), VL_W'(vl_tab[i]), 3'd1, a);
            drain(20);
            check("len_count", done_instr.size(), 64'd1);
            expect_done("len", 0, 32'h1100_0000 + 32'(i), a, lat_tab[i], 1'b0);
        end

        // Five back-to-back vl=16 issues; the first pops immediately so the 5th push fills the FIFO.
        clear_done();
        a0 = 0;
        for (int i = 0; i < 5; i++) begin
            issue(32'h1000 + 32'(i), 16, 2, a);
            if (i == 0) a0 = a;
            check("b2b_ready", ovi.ISSUE_READY, (i == 4) ? 64'd0 : 64'd1);
        end
        ovi.CORE_ISSUE = '{instr: 32'hBAD, vl: 16'd1, sew: 3'd0, valid: 1'b1};
        tick();
        check("b2b_full_ignored_ready", ovi.ISSUE_READY, 64'd0);
        ovi.CORE_ISSUE = '0;
        drain(60);
        check("b2b_count", done_instr.size(), 64'd5);
        for (int i = 0; i < 5; i++) begin
            expect_done("b2b", i, 32'h1000 + 32'(i), a0, 5 + 5 * i, 1'b0);
        end

        // Push coinciding with pop while three ops are queued.
        clear_done();
        a0 = 0;
        for (int i = 0; i < 4; i++) begin
            issue(32'h2000 + 32'(i), 16, 0, a);
            if (i == 0) a0 = a;
            check("pp_fill_ready", ovi.ISSUE_READY, 64'd1);
        end
        tick();
        tick();
        check("pp_first_done", done_instr.size(), 64'd1);
        check("pp_ready_at_3", ovi.ISSUE_READY, 64'd1);
        issue(32'h2004, 16, 0, a);
        check("pp_ready_after_push_pop", ovi.ISSUE_READY, 64'd1);
        issue(32'h2005, 16, 0, a);
        check("pp_full_after_push", ovi.ISSUE_READY, 64'd0);
        drain(60);
        check("pp_count", done_instr.size(), 64'd6);
        for (int i = 0; i < 6; i++) begin
            expect_done("pp", i, 32'h2000 + 32'(i), a0, 5 + 5 * i, 1'b0);
        end

        // Reset mid-EXEC with two ops still queued.
        clear_done();
        for (int i = 0; i < 3; i++) begin
            issue(32'h3000 + 32'(i), 16, 0, a);
        end
        tick();
        RSTN = 1'b0;
        #1;
        check("mid_rst_ready", ovi.ISSUE_READY, 64'd1);
        check("mid_rst_busy", ovi.BUSY, 64'd0);
        check("mid_rst_completed", ovi.CORE_COMPLETED, 64'd0);
        tick();
        tick();
        RSTN = 1'b1;
        repeat (10) tick();
        check("mid_rst_no_completion", done_instr.size(), 64'd0);
        check("mid_rst_busy_after", ovi.BUSY, 64'd0);
        issue(32'h3100, 4, 0, a);
        drain(20);
        check("post_rst_count", done_instr.size(), 64'd1);
        expect_done("post_rst", 0, 32'h3100, a, 2, 1'b0);

        // sew=3 op: illegal fast-retire when the check is built in, otherwise a normal op.
        clear_done();
        issue(32'h4000, 8, 3, a);
        drain(20);
        check("sew3_count", done_instr.size(), 64'd1);
`ifdef OVI_RESP_ILLEGAL_CHECK_EN
        expect_done("sew3", 0, 32'h4000, a, 2, 1'b1);
`else
        expect_done("sew3", 0, 32'h4000, a, 3, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
